// File: rtl/imem_loader.sv
// imem_loader: loads a serial byte stream into instruction memory as
// big-endian 32-bit words at consecutive word addresses. Instruction fetch
// stays disabled (en_im low) for as long as a load is in progress.
module imem_loader #(
   parameter int MEM_BYTES = 32,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [CNT_W-1:0] n_words,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic             wr_en,
   output logic [31:0]      wr_addr,
   output logic [31:0]      wr_data,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             en_im
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [31:0]      r_base;
   logic [CNT_W-1:0] r_n;
   logic [CNT_W-1:0] r_widx;
   logic [1:0]       r_bcnt;
   logic [31:0]      r_pack;
   logic [31:0]      r_wr_addr;
   logic [31:0]      r_wr_data;
   logic             r_err;

   logic [32:0]      w_end;
   logic             w_bad;
   logic             w_take;
   logic             w_last_word;

   // End address of the requested region in 33 bits so it can never wrap.
   assign w_end       = {1'b0, base_addr} + {{(31-CNT_W){1'b0}}, n_words, 2'b00};
   assign w_bad       = (base_addr[1:0] != 2'b00) || (w_end > 33'(MEM_BYTES));
   assign w_take      = rx_valid && (r_state == S_RECV);
   assign w_last_word = (r_widx == r_n - CNT_W'(1));

   // Outputs decoded from state or taken straight from registers.
   assign rx_ready = (r_state == S_RECV);
   assign wr_en    = (r_state == S_WRITE);
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign en_im    = (r_state == S_IDLE);
   assign err      = r_err;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_bad || (n_words == '0)) w_next = S_DONE;
               else                          w_next = S_RECV;
            end
         end
         S_RECV: begin
            if (w_take && (r_bcnt == 2'd3)) w_next = S_WRITE;
         end
         S_WRITE: begin
            if (w_last_word) w_next = S_DONE;
            else             w_next = S_RECV;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: request latch, byte packing, word counter and write outputs.
   // The write address/data are registered when the 4th byte arrives so they
   // are valid throughout WRITE and hold afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base    <= '0;
         r_n       <= '0;
         r_widx    <= '0;
         r_bcnt    <= '0;
         r_pack    <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_base <= base_addr;
                  r_n    <= n_words;
                  r_err  <= w_bad;
                  r_widx <= '0;
                  r_bcnt <= '0;
                  r_pack <= '0;
               end
            end
            S_RECV: begin
               if (w_take) begin
                  r_pack <= {r_pack[23:0], rx_data};
                  r_bcnt <= r_bcnt + 2'd1;
                  if (r_bcnt == 2'd3) begin
                     r_wr_data <= {r_pack[23:0], rx_data};
                     r_wr_addr <= r_base + {{(30-CNT_W){1'b0}}, r_widx, 2'b00};
                  end
               end
            end
            S_WRITE: begin
               r_widx <= r_widx + CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte stream and stalls,
// compared against a word-level reference model of the load.
module tb_imem_loader;
   localparam int MEM_BYTES = 32;
   localparam int CNT_W     = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [31:0]      base_addr;
   logic [CNT_W-1:0] n_words;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready, wr_en, busy, done, err, en_im;
   logic [31:0]      wr_addr, wr_data;

   imem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .n_words(n_words), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done), .err(err), .en_im(en_im)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observed activity, gathered at the falling edge.
   logic [31:0] wq_addr[$];
   logic [31:0] wq_data[$];
   int unsigned wq_cyc[$];
   int unsigned dq_cyc[$];
   int          rdy_cnt, rdy_viol, enim_viol, enim_hi_load;
   bit          in_load = 0;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wq_addr.push_back(wr_addr);
         wq_data.push_back(wr_data);
         wq_cyc.push_back(cyc);
      end
      if (done === 1'b1) dq_cyc.push_back(cyc);
      if (rx_ready === 1'b1) rdy_cnt++;
      if (rx_ready === 1'b1 && (wr_en === 1'b1 || done === 1'b1 || busy !== 1'b1)) rdy_viol++;
      if (en_im !== ~busy) enim_viol++;
      if (in_load && en_im !== 1'b0) enim_hi_load++;
   end

   // Reference model inputs/outputs.
   logic [7:0]  bytes_q[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];

   // Expected write list from the load rules: accepted only if aligned and
   // the region fits in memory; word i = bytes 4i..4i+3, first byte as MSB.
   function automatic bit model(input logic [31:0] base, input int n);
      longint unsigned end_b;
      exp_addr.delete();
      exp_data.delete();
      end_b = longint'(base) + 64'(4 * n);
      if ((base % 4) != 0 || end_b > MEM_BYTES) return 1'b0;
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(base + 32'(4 * i));
         exp_data.push_back({bytes_q[4*i], bytes_q[4*i+1], bytes_q[4*i+2], bytes_q[4*i+3]});
      end
      return 1'b1;
   endfunction

   task automatic fill_bytes(input int cnt);
      bytes_q.delete();
      for (int i = 0; i < cnt; i++) bytes_q.push_back(8'($urandom));
   endtask

   task automatic clear_mon();
      wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); dq_cyc.delete();
      rdy_cnt = 0; rdy_viol = 0; enim_viol = 0; enim_hi_load = 0;
   endtask

   // Issue a start, then stream bytes_q with random stalls until done,
   // a byte-count stop point, or the cycle budget runs out.
   task automatic do_load(input logic [31:0] base, input int n, input int stall_pct,
                          input bit pulse_mid, input int stop_after,
                          output int unsigned n_lbl, output bit to);
      int  idx = 0;
      int  nb;
      int  budget = 0;
      bit  take;
      bit  pulsed = 0;
      nb = bytes_q.size();
      @(posedge clk); #1;
      clear_mon();
      start     = 1'b1;
      base_addr = base;
      n_words   = CNT_W'(n);
      rx_valid  = (nb > 0) && ($urandom_range(99) >= stall_pct);
      rx_data   = (nb > 0) ? bytes_q[0] : 8'($urandom);
      @(posedge clk); #1;
      n_lbl     = cyc;
      start     = 1'b0;
      base_addr = $urandom;
      n_words   = CNT_W'($urandom);
      in_load   = 1'b1;
      to        = 1'b0;
      while (dq_cyc.size() == 0) begin
         if (stop_after >= 0 && idx >= stop_after) break;
         if (budget > 2000) begin to = 1'b1; break; end
         @(negedge clk);
         take = (rx_valid === 1'b1) && (rx_ready === 1'b1);
         @(posedge clk); #1;
         budget++;
         if (take) idx++;
         if (pulse_mid && !pulsed && idx == 2) begin
            start     = 1'b1;
            base_addr = 32'($urandom_range(0, 7)) * 4;
            n_words   = CNT_W'($urandom_range(1, 3));
            pulsed    = 1'b1;
         end else begin
            start = 1'b0;
         end
         rx_valid = (idx < nb) && ($urandom_range(99) >= stall_pct);
         rx_data  = (idx < nb) ? bytes_q[idx] : 8'($urandom);
      end
      start    = 1'b0;
      rx_valid = 1'b0;
      in_load  = 1'b0;
   endtask

   task automatic test_reset();
      int unsigned nl;
      bit to;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({rx_ready, wr_en, busy, done, err, en_im} !== 6'b000001) begin
         n_bad++; $display("FAIL reset_ctl: got %b want 000001", {rx_ready, wr_en, busy, done, err, en_im});
      end
      n_vec++;
      if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
         n_bad++; $display("FAIL reset_wr: got %h/%h want 0/0", wr_addr, wr_data);
      end
      @(negedge clk) rst_n = 1'b1;
      // Partial second word, then reset mid-receive.
      fill_bytes(8);
      do_load(32'h4, 2, 0, 1'b0, 6, nl, to);
      n_vec++;
      if (wq_addr.size() != 1 || wq_addr[0] !== 32'h4) begin
         n_bad++; $display("FAIL reset_pre_write: got %0d writes want 1 at 4", wq_addr.size());
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({rx_ready, wr_en, busy, done, err, en_im} !== 6'b000001) begin
         n_bad++; $display("FAIL reset_mid_ctl: got %b want 000001", {rx_ready, wr_en, busy, done, err, en_im});
      end
      n_vec++;
      if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
         n_bad++; $display("FAIL reset_mid_wr: got %h/%h want 0/0", wr_addr, wr_data);
      end
      @(negedge clk) rst_n = 1'b1;
      bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      do_load(32'h0, 1, 0, 1'b0, -1, nl, to);
      n_vec++;
      if (to || wq_addr.size() != 1 || wq_addr[0] !== 32'h0 || wq_data[0] !== 32'hAABBCCDD) begin
         n_bad++; $display("FAIL reset_reload: got %0d writes (timeout %0b) want 1 x 0:AABBCCDD", wq_addr.size(), to);
      end
   endtask

   task automatic test_five_word();
      int unsigned nl;
      bit to;
      bit acc;
      int k;
      bytes_q = '{8'h01, 8'h23, 8'h00, 8'h00, 8'h14, 8'h15, 8'h00, 8'h00, 8'h36, 8'h14,
                  8'h00, 8'h00, 8'h70, 8'h76, 8'h00, 8'h05, 8'hF0, 8'h89, 8'hAB, 8'h1E};
      acc = model(32'h0, 5);
      do_load(32'h0, 5, 0, 1'b0, -1, nl, to);
      n_vec++;
      if (to || !acc || wq_addr.size() != 5) begin
         n_bad++; $display("FAIL five_count: got %0d writes (timeout %0b) want 5", wq_addr.size(), to);
      end
      for (int i = 0; i < exp_addr.size() && i < wq_addr.size(); i++) begin
         n_vec++;
         if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) begin
            n_bad++; $display("FAIL five_word%0d: got %h:%h want %h:%h", i, wq_addr[i], wq_data[i], exp_addr[i], exp_data[i]);
         end
      end
      for (int i = 1; i < wq_cyc.size(); i++) begin
         n_vec++;
         if (wq_cyc[i] - wq_cyc[i-1] != 5) begin
            n_bad++; $display("FAIL five_spacing%0d: got %0d cycles want 5", i, wq_cyc[i] - wq_cyc[i-1]);
         end
      end
      k = wq_cyc.size();
      n_vec++;
      if (k == 0 || wq_cyc[0] != nl + 4) begin
         n_bad++; $display("FAIL five_first_lat: got %0d want %0d", (k > 0) ? int'(wq_cyc[0] - nl) : -1, 4);
      end
      n_vec++;
      if (k == 0 || dq_cyc.size() != 1 || dq_cyc[0] != wq_cyc[k-1] + 1) begin
         n_bad++; $display("FAIL five_done: got %0d done pulses want 1 right after last write", dq_cyc.size());
      end
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || en_im !== 1'b1) begin
         n_bad++; $display("FAIL five_release: got busy=%b en_im=%b want 0/1", busy, en_im);
      end
      n_vec++;
      if (enim_hi_load != 0 || enim_viol != 0 || err !== 1'b0) begin
         n_bad++; $display("FAIL five_en_im: got %0d/%0d bad cycles err=%b want 0/0 err=0", enim_hi_load, enim_viol, err);
      end
   endtask

   task automatic test_stalls();
      int unsigned nl;
      bit to;
      bit acc;
      for (int pass = 0; pass < 2; pass++) begin
         acc = model(32'h0, 5);
         do_load(32'h0, 5, 30 + 20 * pass, 1'b0, -1, nl, to);
         n_vec++;
         if (to || !acc || wq_addr.size() != 5) begin
            n_bad++; $display("FAIL stall_count: got %0d writes (timeout %0b) want 5", wq_addr.size(), to);
         end
         for (int i = 0; i < exp_addr.size() && i < wq_addr.size(); i++) begin
            n_vec++;
            if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) begin
               n_bad++; $display("FAIL stall_word%0d: got %h:%h want %h:%h", i, wq_addr[i], wq_data[i], exp_addr[i], exp_data[i]);
            end
         end
         n_vec++;
         if (rdy_viol != 0 || enim_hi_load != 0) begin
            n_bad++; $display("FAIL stall_ready: got %0d ready and %0d en_im bad cycles want 0", rdy_viol, enim_hi_load);
         end
      end
   endtask

   task automatic test_reject();
      int unsigned nl;
      bit to;
      logic [31:0] bases[2];
      int          ns[2];
      bases[0] = 32'h1C; ns[0] = 2;
      bases[1] = 32'h2;  ns[1] = $urandom_range(1, 3);
      for (int c = 0; c < 2; c++) begin
         fill_bytes(8);
         n_vec++;
         if (model(bases[c], ns[c]) !== 1'b0) begin
            n_bad++; $display("FAIL reject_model%0d: got accept want reject", c);
         end
         do_load(bases[c], ns[c], 0, 1'b0, -1, nl, to);
         n_vec++;
         if (to || dq_cyc.size() != 1 || dq_cyc[0] != nl) begin
            n_bad++; $display("FAIL reject_done%0d: got %0d pulses (timeout %0b) want 1 right after start", c, dq_cyc.size(), to);
         end
         n_vec++;
         if (err !== 1'b1 || wq_addr.size() != 0 || rdy_cnt != 0) begin
            n_bad++; $display("FAIL reject_resp%0d: got err=%b writes=%0d ready=%0d want 1/0/0", c, err, wq_addr.size(), rdy_cnt);
         end
      end
      repeat (5) @(posedge clk);
      #1;
      n_vec++;
      if (err !== 1'b1) begin
         n_bad++; $display("FAIL reject_sticky: got err=%b want 1", err);
      end
   endtask

   task automatic test_zero_ignored();
      int unsigned nl;
      bit to;
      bit acc;
      fill_bytes(4);
      do_load(32'h8, 0, 0, 1'b0, -1, nl, to);
      n_vec++;
      if (to || dq_cyc.size() != 1 || dq_cyc[0] != nl || err !== 1'b0 || wq_addr.size() != 0) begin
         n_bad++; $display("FAIL zero_len: got done=%0d err=%b writes=%0d want 1/0/0", dq_cyc.size(), err, wq_addr.size());
      end
      fill_bytes(12);
      acc = model(32'h4, 3);
      do_load(32'h4, 3, 20, 1'b1, -1, nl, to);
      n_vec++;
      if (to || !acc || wq_addr.size() != 3) begin
         n_bad++; $display("FAIL ignore_count: got %0d writes (timeout %0b) want 3", wq_addr.size(), to);
      end
      for (int i = 0; i < exp_addr.size() && i < wq_addr.size(); i++) begin
         n_vec++;
         if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) begin
            n_bad++; $display("FAIL ignore_word%0d: got %h:%h want %h:%h", i, wq_addr[i], wq_data[i], exp_addr[i], exp_data[i]);
         end
      end
      repeat (8) @(posedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b0 || wq_addr.size() != 3) begin
         n_bad++; $display("FAIL ignore_after: got busy=%b writes=%0d want 0/3", busy, wq_addr.size());
      end
   endtask

   task automatic test_full();
      int unsigned nl;
      bit to;
      bit acc;
      logic [31:0] bases[3];
      int          ns[3];
      bases[0] = 32'h0; ns[0] = 8;
      bases[1] = 32'h4; ns[1] = 7;
      bases[2] = 32'h4; ns[2] = 8;
      for (int c = 0; c < 3; c++) begin
         fill_bytes(4 * ns[c]);
         acc = model(bases[c], ns[c]);
         do_load(bases[c], ns[c], 10, 1'b0, -1, nl, to);
         n_vec++;
         if (to || err !== !acc || wq_addr.size() != exp_addr.size()) begin
            n_bad++; $display("FAIL full_resp%0d: got err=%b writes=%0d want err=%b writes=%0d", c, err, wq_addr.size(), !acc, exp_addr.size());
         end
         for (int i = 0; i < exp_addr.size() && i < wq_addr.size(); i++) begin
            n_vec++;
            if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) begin
               n_bad++; $display("FAIL full_word%0d_%0d: got %h:%h want %h:%h", c, i, wq_addr[i], wq_data[i], exp_addr[i], exp_data[i]);
            end
         end
         if (acc) begin
            n_vec++;
            if (wq_addr.size() == 0 || wq_addr[wq_addr.size()-1] !== 32'h1C) begin
               n_bad++; $display("FAIL full_last%0d: got %0d writes want last at 1c", c, wq_addr.size());
            end
         end
      end
   endtask

   task automatic test_random();
      int unsigned nl;
      bit to;
      bit acc;
      logic [31:0] b;
      int n;
      for (int it = 0; it < 8; it++) begin
         b = 32'($urandom_range(0, 40));
         if ($urandom_range(1) == 1) b = b & 32'hFFFF_FFFC;
         n = $urandom_range(0, 9);
         fill_bytes(4 * n);
         acc = model(b, n);
         do_load(b, n, $urandom_range(0, 60), 1'b0, -1, nl, to);
         n_vec++;
         if (to || err !== !acc || wq_addr.size() != exp_addr.size() || dq_cyc.size() != 1) begin
            n_bad++; $display("FAIL rand%0d_resp base=%h n=%0d: got err=%b writes=%0d want err=%b writes=%0d", it, b, n, err, wq_addr.size(), !acc, exp_addr.size());
         end
         for (int i = 0; i < exp_addr.size() && i < wq_addr.size(); i++) begin
            n_vec++;
            if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) begin
               n_bad++; $display("FAIL rand%0d_word%0d: got %h:%h want %h:%h", it, i, wq_addr[i], wq_data[i], exp_addr[i], exp_data[i]);
            end
         end
      end
   endtask

   initial begin
      rst_n     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      n_words   = '0;
      rx_data   = '0;
      rx_valid  = 1'b0;
      test_reset();
      test_five_word();
      test_stalls();
      test_reject();
      test_zero_ignored();
      test_full();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the byte-addressed, big-endian instruction memory from a serial byte stream before the core fetches. It accepts bytes over a valid/ready handshake, packs every four into a 32-bit instruction word with the first byte as the MSB, and issues one word write per packed word at consecutive word addresses. It drives `en_im` low while a load is in progress, so the instruction memory is never read during loading.

## Interface
Parameters:
- `MEM_BYTES`, 32: instruction memory size in bytes. Must be a multiple of 4.
- `CNT_W`, 8: width of the word-count input.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  load request; sampled only in IDLE.
- `base_addr`  in  32  byte address of the first word; must be word-aligned. Latched at start.
- `n_words`  in  CNT_W  number of words to load. Latched at start.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `wr_en`  out  1  one-cycle memory write strobe.
- `wr_addr`  out  32  byte address of the word being written.
- `wr_data`  out  32  packed word, `{b0,b1,b2,b3}`.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when a load completes or is rejected.
- `err`  out  1  sticky: last start was rejected.
- `en_im`  out  1  fetch enable to instruction memory; equals `!busy`.

## Operation
State machine:
- **IDLE**
  - On `start`: latch `base_addr` and `n_words`, clear `err`.
  - If `base_addr[1:0]!=0` or `base_addr + 4*n_words > MEM_BYTES`: set `err`, go to DONE. The range check uses 33-bit arithmetic so no wrap is possible.
  - Else if `n_words==0`: go to DONE.
  - Else: go to RECV.
- **RECV**
  - `rx_ready=1`.
  - Each accepted byte (`rx_valid && rx_ready`) shifts into a 32-bit packing register, MSB first, and increments a 2-bit byte counter.
  - On the 4th accepted byte, go to WRITE.
- **WRITE**
  - `rx_ready=0`, `wr_en=1`, `wr_data` = packed word, `wr_addr = base + 4*word_idx`.
  - Increment `word_idx`.
  - If `word_idx == n_words-1`: go to DONE. Else return to RECV with the byte counter at 0.
- **DONE**
  - `done=1` for one cycle, then go to IDLE.

Rules:
- `busy=1` in RECV, WRITE and DONE. `en_im = !busy`.
- `start` while not in IDLE is ignored. Changes to `base_addr` and `n_words` after latching have no effect.
- `rx_valid` outside RECV is ignored; no byte is consumed.
- `rx_valid` low in RECV stalls the load indefinitely; the partial word is held.
- `wr_addr` and `wr_data` hold their last written values outside WRITE.
- `err` stays set until the next accepted `start` or reset.
- Reset asserted mid-load, at any time: the FSM returns to IDLE, the partial word is discarded, and words already written are not rolled back.

## Timing
- Reset values:
  - `rx_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`
  - `busy=0`, `done=0`, `err=0`, `en_im=1`
  - Internal counters and packing register are 0.
- `start` high at edge N (in IDLE): `busy=1` and `en_im=0` from N+1; `rx_ready=1` from N+1, or `done=1` at N+1 for a rejected or zero-length load.
- 4th byte accepted at edge M: `wr_en=1` during cycle M+1 with `rx_ready=0`; `rx_ready=1` again from M+2.
- Peak throughput: 4 bytes per 5 cycles.
- Last write at cycle W: `done=1` at W+1; `busy=0` and `en_im=1` at W+2.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert `rst_n=0` mid-RECV after 2 bytes -> all outputs at reset values. Then `start` with `base=0`, `n=1`, bytes `AA BB CC DD` -> single write `addr=0`, `data=32'hAABBCCDD`.
- **Five-word load:** `base=0`, `n=5`, bytes `01 23 00 00 14 15 00 00 36 14 00 00 70 76 00 05 F0 89 AB 1E` with `rx_valid` held high -> writes `0:01230000`, `4:14150000`, `8:36140000`, `C:70760005`, `10:F089AB1E`. Consecutive writes are exactly 5 cycles apart. `done` one cycle after the last write. `en_im=0` throughout the load.
- **Stalls:** same load with `rx_valid` randomly deasserted -> identical write sequence; `rx_ready` low only in WRITE, DONE and IDLE.
- **Rejection:** `base=0x1C`, `n=2` (needs 36 bytes > 32) -> `done` at N+1, `err=1`, no `wr_en`, `rx_ready` never high. `base=0x2` -> same response.
- **Zero length / ignored start:** `n=0` -> `done` at N+1, `err=0`, no write. `start` pulsed during RECV -> ignored; the original load completes unchanged.
- **Full memory:** `base=0`, `n=8` -> last write at `addr=0x1C`, `err=0`. `base=4`, `n=7` accepted; `base=4`, `n=8` rejected.
